display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed 7-segment digits.
REQ-002 Parameter DWELL_CYCLES, default 100_000, clk cycles a digit is lit per slot (1 ms at 100 MHz).
REQ-003 Parameter GUARD_CYCLES, default 1_000, clk cycles all anodes are off before each slot (anti-ghosting).
REQ-004 clk  in  1  single system clock, rising edge; the block SHALL use only this clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  write strobe into the shadow digit buffer.
REQ-007 wr_addr  in  3  digit index 0..7 (0 = rightmost, anode bit 0).
REQ-008 wr_data  in  5  bit4 = blank, bits3:0 = hex value.
REQ-009 commit  in  1  request to copy the shadow buffer to the active buffer at the next frame boundary.
REQ-010 en_mask  in  8  per-digit enable; 0 forces that digit dark.
REQ-011 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 an  out  8  anode selects, active-low, at most one bit low.
REQ-013 frame_done  out  1  one-cycle pulse when digit 7's slot ends.
REQ-014 commit_pending  out  1  high from an accepted commit until the copy completes.

Function
REQ-015 wr_en high SHALL write wr_data into shadow[wr_addr] at that clock edge; the active buffer SHALL NOT change.
REQ-016 FSM states: GUARD, SHOW; GUARD lasts exactly GUARD_CYCLES cycles, then SHOW lasts exactly DWELL_CYCLES cycles, then GUARD again.
REQ-017 In GUARD, an SHALL be 8'hFF and seg SHALL be 7'h7F.
REQ-018 On the GUARD->SHOW transition, en_mask[idx] SHALL be sampled into a register held for the whole SHOW.
REQ-019 In SHOW, an[idx] SHALL be 0 only if the sampled enable is 1 and active[idx].blank is 0; otherwise an = 8'hFF and seg = 7'h7F.
REQ-020 In SHOW with the digit lit, seg SHALL equal the hex decode of active[idx].value: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 At the end of SHOW, idx SHALL increment modulo NUM_DIGITS; disabled or blank digits SHALL still consume their full slot (constant frame period = NUM_DIGITS*(GUARD_CYCLES+DWELL_CYCLES)).
REQ-022 frame_done SHALL pulse high for exactly one cycle, on the cycle idx wraps from 7 to 0.
REQ-023 commit high while commit_pending is 0 SHALL set commit_pending on the next edge; commit while pending SHALL be ignored.
REQ-024 On the frame-boundary edge (idx 7->0) with commit_pending already 1, all 8 shadow entries SHALL be copied to active and commit_pending cleared on the same edge.
REQ-025 A commit asserted on the boundary cycle itself SHALL be deferred to the following frame boundary.
REQ-026 A write coinciding with the copy edge SHALL update the shadow only; the active buffer receives the pre-write shadow value.
REQ-027 Cycle counters SHALL be sized to hold max(GUARD_CYCLES, DWELL_CYCLES)-1 without overflow; seg/an SHALL be registered outputs.

Reset
REQ-028 rst SHALL force: state GUARD, idx 0, cycle counter 0, all shadow and active entries to blank=1 value=0, seg 7'h7F, an 8'hFF, frame_done 0, commit_pending 0.
REQ-029 rst asserted mid-slot or mid-commit SHALL abort it; no partial copy; scanning restarts at digit 0 GUARD on the first cycle after rst deasserts.

Structure
REQ-030 Shared package display_pkg SHALL hold the state enum (GUARD, SHOW), NUM_DIGITS default, the blank pattern 7'h7F and the 16 segment constants.
REQ-031 Segment decoding SHALL be a separate combinational sub-module hex_seg_decoder (4-bit in, 7-bit active-low out).

Verification (bench uses DWELL_CYCLES=4, GUARD_CYCLES=2)
REQ-032 Reset release, no writes -> an=FF, seg=7F for all frames; frame_done every 48 cycles.
REQ-033 Write addr 3 data 0x05, commit -> commit_pending high until next frame boundary; in the following frame an=F7, seg=0010010 for exactly 4 cycles, dark otherwise.
REQ-034 Write 0x0A to all 8 digits, commit, en_mask=0x55 -> only an bits 0,2,4,6 go low, each for 4 cycles with seg=0001000; odd slots stay dark but keep timing.
REQ-035 commit on the boundary cycle -> no copy at that boundary, copy at the next; write to addr 0 on the copy edge -> active[0] keeps the old shadow value.
REQ-036 rst pulse during digit 5 SHOW -> next cycle an=FF, all digits blank, pending 0; the next lit slot is digit 0 only after rewrite and commit.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the 7-segment scan controller
// Holds the scan FSM state enum, the default digit count, the dark segment
// pattern, the reset value of a digit entry and the 16 hex segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int DEFAULT_NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit entry: bit4 = blank, bits3:0 = hex value.
    localparam logic [4:0] ENTRY_BLANK = 5'h10;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/hex_seg_decoder.sv
// rtl/hex_seg_decoder.sv - combinational hex to 7-segment decoder
// Ports:
//   value  in  4  hex digit 0..F
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-low
module hex_seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 7-segment scan controller with double-buffered digits
// Ports:
//   clk            in  1  system clock, rising edge
//   rst            in  1  synchronous active-high reset
//   wr_en          in  1  write strobe into shadow buffer
//   wr_addr        in  3  digit index (0 = rightmost, anode bit 0)
//   wr_data        in  5  bit4 = blank, bits3:0 = hex value
//   commit         in  1  request shadow->active copy at next frame boundary
//   en_mask        in  8  per-digit enable, 0 forces the digit dark
//   seg            out 7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an             out 8  anode selects, active-low, registered
//   frame_done     out 1  one-cycle pulse after digit 7's slot ends
//   commit_pending out 1  commit accepted, copy not yet done
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int DWELL_CYCLES = 100_000,
    parameter int GUARD_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       commit,
    input  logic [7:0] en_mask,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       frame_done,
    output logic       commit_pending
);

    localparam int CNT_MAX = ((DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES) - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    scan_state_t   state;
    scan_state_t   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          en_lat;
    logic          show_start;
    logic          wrap;
    logic          lit_next;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_next;
    logic [7:0]    an_next;

    logic [4:0] shadow [NUM_DIGITS];
    logic [4:0] active [NUM_DIGITS];

    hex_seg_decoder u_dec (
        .value (active[idx][3:0]),
        .seg   (dec_seg)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        show_start = 1'b0;
        wrap       = 1'b0;
        case (state)
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                    show_start = 1'b1;
                end
            end
            SHOW: begin
                if (cnt == DWELL_LAST) begin
                    state_next = GUARD;
                    cnt_next   = '0;
                    wrap       = (idx == LAST_IDX);
                    idx_next   = wrap ? 3'd0 : idx + 3'd1;
                end
            end
            default: begin
                state_next = GUARD;
                cnt_next   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state:
        // an/seg then change on the same edge as the state itself. On the
        // GUARD->SHOW edge the enable latch is not loaded yet, so the live
        // mask bit is used directly. The active buffer only changes on a
        // SHOW->GUARD edge, where the next outputs are dark anyway.
        lit_next = (state_next == SHOW)
                 && (show_start ? en_mask[idx] : en_lat)
                 && !active[idx][4];
        an_next  = lit_next ? ~(8'd1 << idx) : 8'hFF;
        seg_next = lit_next ? dec_seg : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= GUARD;
            cnt            <= '0;
            idx            <= 3'd0;
            en_lat         <= 1'b0;
            seg            <= SEG_BLANK;
            an             <= 8'hFF;
            frame_done     <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= ENTRY_BLANK;
                active[i] <= ENTRY_BLANK;
            end
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            seg        <= seg_next;
            an         <= an_next;
            frame_done <= wrap;
            if (show_start) begin
                en_lat <= en_mask[idx];
            end
            // A commit arriving on the boundary cycle only arms the request,
            // so the copy happens at the following boundary.
            if (wrap && commit_pending) begin
                active         <= shadow;
                commit_pending <= 1'b0;
            end else if (commit && !commit_pending) begin
                commit_pending <= 1'b1;
            end
            // The copy above reads the pre-edge shadow, so a simultaneous
            // write lands in the shadow only.
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;

    localparam int G     = 2;
    localparam int D     = 4;
    localparam int N     = 8;
    localparam int SLOT  = G + D;
    localparam int FRAME = N * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       commit;
    logic [7:0] en_mask;
    logic [6:0] seg;
    logic [7:0] an;
    logic       frame_done;
    logic       commit_pending;

    display_scan_controller #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (D),
        .GUARD_CYCLES (G)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .en_mask        (en_mask),
        .seg            (seg),
        .an             (an),
        .frame_done     (frame_done),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [16];

    logic [4:0] m_shadow [N];
    logic [4:0] m_active [N];
    bit         m_pend;
    bit         m_en_samp;
    int         t;

    int         lit_cnt;
    logic [7:0] low_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h t=%0d", tag, obs, exp, t);
        end
    endtask

    // One clock edge: the reference advances a cycle counter t since reset
    // and derives digit/slot position from it arithmetically.
    task automatic step();
        int         digit;
        int         phase;
        bit         lit;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        if (rst) begin
            t = 0;
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 5'h10;
                m_active[i] = 5'h10;
            end
            m_pend    = 1'b0;
            m_en_samp = 1'b0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && m_pend) begin
                for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                m_pend = 1'b0;
            end else if (commit && !m_pend) begin
                m_pend = 1'b1;
            end
            if ((t % SLOT) == G - 1) m_en_samp = en_mask[(t / SLOT) % N];
            if (wr_en) m_shadow[wr_addr] = wr_data;
            t++;
        end
        digit   = (t / SLOT) % N;
        phase   = t % SLOT;
        lit     = (phase >= G) && m_en_samp && !m_active[digit][4];
        exp_an  = lit ? ~(8'h01 << digit) : 8'hFF;
        exp_seg = lit ? seg_tab[m_active[digit][3:0]] : 7'h7F;
        #1;
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("frame_done", 32'(frame_done), 32'((t > 0) && (t % FRAME == 0)));
        check("commit_pending", 32'(commit_pending), 32'(m_pend));
        if (an !== 8'hFF) lit_cnt++;
        low_seen = low_seen | ~an;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
        t = 0; lit_cnt = 0; low_seen = 8'h00;

        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 5'd0;
        commit = 1'b0; en_mask = 8'hFF;
        run(3);
        rst = 1'b0;

        // Blank buffers: dark for two frames whatever the mask does.
        lit_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            en_mask = 8'($urandom);
            step();
        end
        check("dark_after_reset", 32'(lit_cnt), 32'd0);

        // Single digit 3 = 5.
        en_mask = 8'hFF;
        do_write(3'd3, 5'h05);
        do_commit();
        check("pending_after_commit", 32'(commit_pending), 32'd1);
        run_to(0);
        lit_cnt = 0; low_seen = 8'h00;
        run(FRAME);
        check("digit3_lit_cycles", 32'(lit_cnt), 32'd4);
        check("digit3_anodes", 32'(low_seen), 32'h08);

        // All digits = A, even digits enabled only.
        for (int i = 0; i < N; i++) do_write(3'(i), 5'h0A);
        do_commit();
        en_mask = 8'h55;
        run_to(0);
        lit_cnt = 0; low_seen = 8'h00;
        run(FRAME);
        check("even_lit_cycles", 32'(lit_cnt), 32'd16);
        check("even_anodes", 32'(low_seen), 32'h55);

        // Commit on the boundary cycle, then write on the copy edge.
        en_mask = 8'hFF;
        do_write(3'd0, 5'h07);
        run_to(FRAME - 1);
        do_commit();
        check("boundary_commit_deferred", 32'(commit_pending), 32'd1);
        run_to(G);
        check("digit0_still_old", 32'(seg), 32'(7'b0001000));
        run_to(FRAME - 1);
        do_write(3'd0, 5'h03);
        check("copy_done", 32'(commit_pending), 32'd0);
        run_to(G);
        check("digit0_pre_write_value", 32'(seg), 32'(7'b1111000));

        // Reset during digit 5 show with a commit pending.
        do_write(3'd1, 5'h0E);
        do_commit();
        run_to(5 * SLOT + G + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_an", 32'(an), 32'hFF);
        check("rst_pending", 32'(commit_pending), 32'd0);
        lit_cnt = 0;
        run(2 * FRAME);
        check("dark_after_mid_reset", 32'(lit_cnt), 32'd0);
        do_write(3'd0, 5'h01);
        do_commit();
        run_to(0);
        low_seen = 8'h00;
        run(SLOT);
        check("first_lit_digit0", 32'(low_seen), 32'h01);

        // Randomized traffic against the reference.
        for (int i = 0; i < 30 * FRAME; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            wr_data = 5'($urandom);
            commit  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) en_mask = 8'($urandom);
            step();
        end
        wr_en = 1'b0; commit = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
